// File: rtl/spi_byte_recv.sv
// Mode-0 SPI byte receiver: synchronizes the SPI pins into clk, shifts bits in MSB-first
// on rising sclk and hands each completed byte to the consumer on a valid/ack register.
module spi_byte_recv #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_sclk,
   input  logic       spi_sdi,
   input  logic       spi_cs_n,
   input  logic       ack,
   input  logic       ovr_clr,
   output logic [7:0] data,
   output logic       valid,
   output logic       busy,
   output logic       frame_end,
   output logic       frame_err,
   output logic       overrun
);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync, sdi_sync, cs_sync;
   logic [SYNC_STAGES-1:0] primed;
   logic                   sclk_prev, cs_prev;
   logic                   sclk_s, sdi_s, cs_s;
   logic                   sclk_rise, cs_fall, cs_rise;
   logic                   armed;
   logic [2:0]             bit_cnt;
   logic [7:0]             shift_q;
   logic [7:0]             byte_nxt;

   logic start_frame, shift_en, end_frame, byte_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync <= '0;
         sdi_sync  <= '1;
         cs_sync   <= '1;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b1;
         primed    <= '0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         sclk_prev <= sclk_s;
         cs_prev   <= cs_s;
         primed    <= {primed[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign sdi_s     = sdi_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev;
   assign cs_fall   = ~cs_s & cs_prev;
   assign cs_rise   = cs_s & ~cs_prev;

   // The synchronizers hold their idle reset values for a few cycles after reset, so
   // arming waits until they carry real pin samples; a low cs_n at reset is never armed.
   always_ff @(posedge clk) begin
      if (rst)                             armed <= 1'b0;
      else if (primed[SYNC_STAGES-1] && cs_s) armed <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cs_fall && armed) state_nxt = ACTIVE;
         ACTIVE:  if (cs_rise)          state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state == ACTIVE);
      start_frame = (state == IDLE) && cs_fall && armed;
      end_frame   = (state == ACTIVE) && cs_rise;
      shift_en    = (state == ACTIVE) && sclk_rise && !cs_rise;
      byte_done   = shift_en && (bit_cnt == 3'd7);
   end

   assign byte_nxt = {shift_q[6:0], sdi_s};

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt <= 3'd0;
         shift_q <= 8'h00;
      end else if (start_frame || end_frame) begin
         bit_cnt <= 3'd0;
         shift_q <= 8'h00;
      end else if (shift_en) begin
         bit_cnt <= bit_cnt + 3'd1;
         shift_q <= byte_nxt;
      end
   end

   // Handshake: valid holds data until the consumer raises ack while valid=1; a byte
   // completing in the ack cycle replaces data directly, otherwise it is dropped as overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         data    <= 8'h00;
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (byte_done) begin
            if (!valid || ack) begin
               data  <= byte_nxt;
               valid <= 1'b1;
            end
         end else if (valid && ack) begin
            valid <= 1'b0;
         end
         if (byte_done && valid && !ack) overrun <= 1'b1;
         else if (ovr_clr)               overrun <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_end <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_end <= end_frame;
         frame_err <= end_frame && (bit_cnt != 3'd0);
      end
   end

endmodule

// File: tb/tb_spi_byte_recv.sv
// Bench for spi_byte_recv: drives SPI frames pin-level and scoreboards delivered bytes
// against an expected queue filled when each byte is sent.
module tb_spi_byte_recv;

   localparam int PH = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       spi_sclk = 1'b0;
   logic       spi_sdi = 1'b1;
   logic       spi_cs_n = 1'b1;
   logic       ack = 1'b0;
   logic       ovr_clr = 1'b0;
   logic [7:0] data;
   logic       valid, busy, frame_end, frame_err, overrun;

   int checks = 0;
   int errors = 0;
   int fe_cnt = 0;
   int ferr_cnt = 0;

   logic [7:0] exp_q[$];
   logic       valid_d = 1'b0;
   logic [7:0] data_d = 8'h00;

   spi_byte_recv #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst),
      .spi_sclk(spi_sclk), .spi_sdi(spi_sdi), .spi_cs_n(spi_cs_n),
      .ack(ack), .ovr_clr(ovr_clr),
      .data(data), .valid(valid), .busy(busy),
      .frame_end(frame_end), .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Scoreboard: a fresh byte shows up as valid rising or data changing while valid.
   always @(negedge clk) begin
      if (valid === 1'b1 && (valid_d !== 1'b1 || data !== data_d)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL deliver_unexpected got=%h expected=none", data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (data !== e) begin
               errors++;
               $display("FAIL deliver_order got=%h expected=%h", data, e);
            end
         end
      end
      if (frame_end === 1'b1) fe_cnt++;
      if (frame_err === 1'b1) ferr_cnt++;
      valid_d = valid;
      data_d  = data;
   end

   task automatic send_bits(input logic [7:0] b, input int nbits, input bit coack, input bit chk_lat);
      for (int i = 0; i < nbits; i++) begin
         spi_sdi = b[7-i];
         repeat (PH) @(negedge clk);
         spi_sclk = 1'b1;
         if (i == nbits - 1 && (coack || chk_lat)) begin
            @(negedge clk);
            @(negedge clk);
            if (chk_lat) begin
               checks++;
               if (valid !== 1'b0) begin
                  errors++;
                  $display("FAIL latency_early valid=%b expected=0", valid);
               end
            end
            if (coack) ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            if (chk_lat) begin
               checks++;
               if (valid !== 1'b1) begin
                  errors++;
                  $display("FAIL latency_valid valid=%b expected=1", valid);
               end
            end
            repeat (PH - 3) @(negedge clk);
         end else begin
            repeat (PH) @(negedge clk);
         end
         spi_sclk = 1'b0;
      end
      spi_sdi = 1'b1;
   endtask

   task automatic cs_low();
      spi_cs_n = 1'b0;
      repeat (PH) @(negedge clk);
   endtask

   task automatic cs_high();
      repeat (PH) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (PH) @(negedge clk);
   endtask

   task automatic do_ack(input string name);
      int n;
      n = 0;
      while (valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (valid !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout valid=%b expected=1", name, valid);
      end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({data, valid, busy, frame_end, frame_err, overrun} !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs got=%h expected=0", {data, valid, busy, frame_end, frame_err, overrun});
      end
   endtask

   task automatic test_single();
      int fe0, ferr0;
      fe0 = fe_cnt; ferr0 = ferr_cnt;
      exp_q.push_back(8'hA5);
      cs_low();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b expected=1", busy); end
      send_bits(8'hA5, 8, 1'b0, 1'b1);
      checks++;
      if (data !== 8'hA5) begin errors++; $display("FAIL single_data got=%h expected=a5", data); end
      cs_high();
      checks++;
      if (fe_cnt - fe0 != 1 || ferr_cnt - ferr0 != 0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL single_frame fe=%0d ferr=%0d ovr=%b expected=1 0 0", fe_cnt - fe0, ferr_cnt - ferr0, overrun);
      end
      do_ack("single");
      checks++;
      if (valid !== 1'b0) begin errors++; $display("FAIL single_ack valid=%b expected=0", valid); end
   endtask

   task automatic test_back_to_back();
      int fe0;
      fe0 = fe_cnt;
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'hFF);
      cs_low();
      send_bits(8'h3C, 8, 1'b0, 1'b0);
      do_ack("b2b_first");
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_mid got=%b expected=1", busy); end
      send_bits(8'hFF, 8, 1'b0, 1'b0);
      do_ack("b2b_second");
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_end got=%b expected=1", busy); end
      cs_high();
      checks++;
      if (fe_cnt - fe0 != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_frame fe=%0d busy=%b expected=1 0", fe_cnt - fe0, busy);
      end
   endtask

   task automatic test_overrun();
      exp_q.push_back(8'h11);
      cs_low();
      send_bits(8'h11, 8, 1'b0, 1'b0);
      send_bits(8'h22, 8, 1'b0, 1'b0);
      cs_high();
      checks++;
      if (data !== 8'h11 || overrun !== 1'b1 || valid !== 1'b1) begin
         errors++;
         $display("FAIL overrun_set data=%h ovr=%b valid=%b expected=11 1 1", data, overrun, valid);
      end
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      checks++;
      if (overrun !== 1'b0 || data !== 8'h11) begin
         errors++;
         $display("FAIL overrun_clr ovr=%b data=%h expected=0 11", overrun, data);
      end
      do_ack("overrun");
   endtask

   task automatic test_coincident_ack();
      exp_q.push_back(8'h96);
      exp_q.push_back(8'h5A);
      cs_low();
      send_bits(8'h96, 8, 1'b0, 1'b0);
      send_bits(8'h5A, 8, 1'b1, 1'b0);
      checks++;
      if (valid !== 1'b1 || data !== 8'h5A || overrun !== 1'b0) begin
         errors++;
         $display("FAIL coack valid=%b data=%h ovr=%b expected=1 5a 0", valid, data, overrun);
      end
      cs_high();
      do_ack("coack");
   endtask

   task automatic test_partial();
      int fe0, ferr0;
      fe0 = fe_cnt; ferr0 = ferr_cnt;
      cs_low();
      send_bits(8'hF8, 5, 1'b0, 1'b0);
      cs_high();
      checks++;
      if (fe_cnt - fe0 != 1 || ferr_cnt - ferr0 != 1 || valid !== 1'b0) begin
         errors++;
         $display("FAIL partial_frame fe=%0d ferr=%0d valid=%b expected=1 1 0", fe_cnt - fe0, ferr_cnt - ferr0, valid);
      end
      exp_q.push_back(8'h80);
      cs_low();
      send_bits(8'h80, 8, 1'b0, 1'b0);
      checks++;
      if (data !== 8'h80) begin errors++; $display("FAIL partial_next data=%h expected=80", data); end
      cs_high();
      do_ack("partial");
   endtask

   task automatic test_reset_mid();
      int fe0, ferr0;
      cs_low();
      send_bits(8'hE0, 3, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      fe0 = fe_cnt; ferr0 = ferr_cnt;
      checks++;
      if ({data, valid, busy, frame_end, frame_err, overrun} !== 13'd0) begin
         errors++;
         $display("FAIL rstmid_outputs got=%h expected=0", {data, valid, busy, frame_end, frame_err, overrun});
      end
      send_bits(8'h55, 5, 1'b0, 1'b0);
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_ignored valid=%b busy=%b expected=0 0", valid, busy);
      end
      cs_high();
      checks++;
      if (fe_cnt - fe0 != 0 || ferr_cnt - ferr0 != 0) begin
         errors++;
         $display("FAIL rstmid_noframe fe=%0d ferr=%0d expected=0 0", fe_cnt - fe0, ferr_cnt - ferr0);
      end
      exp_q.push_back(8'hC3);
      cs_low();
      send_bits(8'hC3, 8, 1'b0, 1'b0);
      cs_high();
      checks++;
      if (data !== 8'hC3 || valid !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_next data=%h valid=%b expected=c3 1", data, valid);
      end
      do_ack("rstmid");
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overrun();
      test_coincident_ack();
      test_partial();
      test_reset_mid();
      repeat (4) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drained left=%0d expected=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_byte_recv.md
# spi_byte_recv

Mode-0 SPI byte receiver: the peripheral-side counterpart of the team's SPI byte transmitter. It oversamples the external SPI pins (sclk, data, chip select) in the `clk` domain and shifts in data MSB-first on rising sclk edges. Each completed 8-bit byte is presented on a valid/ack holding register. It also reports frame boundaries, aborted partial bytes and overruns to the consuming logic, such as the audio or command front-end.

## Interface
- `SYNC_STAGES`, 2, synchronizer flip-flops per SPI input; legal values 2–3.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `spi_sclk`  in  1  SPI clock, asynchronous; idles low.
- `spi_sdi`  in  1  serial data, asynchronous; idles high; MSB first.
- `spi_cs_n`  in  1  chip select, asynchronous, active low.
- `ack`  in  1  consumer accepts `data`; meaningful only while `valid`=1.
- `ovr_clr`  in  1  clears sticky `overrun`.
- `data`  out  8  last completed byte; stable while `valid`=1.
- `valid`  out  1  `data` holds an unconsumed byte.
- `busy`  out  1  frame in progress (state ACTIVE).
- `frame_end`  out  1  one-cycle pulse when chip select deasserts after an ACTIVE frame.
- `frame_err`  out  1  one-cycle pulse when chip select deasserts with a partial byte (1–7 bits) received.
- `overrun`  out  1  sticky; a byte completed while `valid`=1 and no `ack`.

## Operation
- **Input synchronization**
  - Each SPI input passes through `SYNC_STAGES` flops.
  - Reset values of the synchronizers are the idle levels: sclk=0, sdi=1, cs_n=1.
  - One extra flop per sclk/cs_n provides the previous value for edge detection.
  - `sclk_rise` = synced sclk 0→1; `cs_fall` and `cs_rise` are defined on synced cs_n.
- **Arming**
  - `armed` flag, cleared by reset, set whenever synced cs_n=1.
  - `cs_fall` is honored only when `armed`=1. After a reset during a low chip select, the receiver therefore waits for the next full frame.
- **FSM states**
  - IDLE: `busy`=0; sclk edges ignored. On `cs_fall` with `armed`=1 → ACTIVE, bit count ← 0, shift register ← 0.
  - ACTIVE: on `sclk_rise`, shift ← {shift[6:0], synced sdi} and bit count += 1. A `sclk_rise` in the same cycle as the entering `cs_fall` is ignored.
  - Byte completion (8th rising edge): bit count wraps to 0; the delivery rule below applies; the FSM stays in ACTIVE.
  - ACTIVE on `cs_rise` → IDLE: pulse `frame_end`. If bit count ≠ 0, also pulse `frame_err` and discard the partial byte. A `sclk_rise` coincident with `cs_rise` is ignored.
- **Delivery rule** (evaluated at byte completion)
  - `valid`=0 → load `data`, set `valid`.
  - `valid`=1 and `ack`=1 in the same cycle → load new `data`, `valid` stays 1, no overrun.
  - `valid`=1 and `ack`=0 → new byte dropped, old `data` kept, `overrun` ← 1.
- **Ack and overrun clearing**
  - `ack` with `valid`=1 and no completion → `valid` ← 0 next cycle.
  - `ack` with `valid`=0 is ignored.
  - `ovr_clr` clears `overrun` next cycle; a simultaneous new overrun wins (stays 1).
- **Reset values**: `data`=0x00; `valid`, `busy`, `frame_end`, `frame_err`, `overrun` all 0; FSM IDLE; bit count 0; `armed` 0.

## Timing
- Latency from an external sclk rising edge to its internal `sclk_rise`: `SYNC_STAGES`+1 clk cycles.
- `valid` rises one cycle after the 8th `sclk_rise`.
- `frame_end` and `frame_err` pulse in the cycle after `cs_rise` is detected.
- Input constraints:
  - sclk high and low phases each ≥ `SYNC_STAGES`+2 clk cycles.
  - cs_n low-to-first-sclk-rise ≥ `SYNC_STAGES`+2 clk cycles.
  - With the transmitter's tick-paced phases, the tick period must be ≥ 4 clk cycles at `SYNC_STAGES`=2.
- sdi is sampled from the same synchronizer depth as sclk. The data line must be stable from ≥1 clk before the sclk rise until ≥ `SYNC_STAGES`+1 clk after it; the transmitter changes data only with sclk low.
- Throughput: one byte per 8 sclk periods. The consumer must `ack` within 8 sclk periods to avoid overrun.

## Test plan
- Single frame: cs_n low, byte 0xA5 MSB first, cs_n high → `data`=0xA5, `valid`=1 one cycle after 8th detected rise; `frame_end` pulses once; `frame_err`=0; `overrun`=0.
- Back-to-back bytes in one frame: 0x3C then 0xFF, with `ack` after each → two deliveries in order; `busy`=1 throughout; single `frame_end`.
- Overrun: send 0x11, 0x22 with no `ack` → `data`=0x11, `overrun`=1. Then `ovr_clr` → `overrun`=0 and `data` still 0x11.
- Coincident ack: assert `ack` in the exact cycle the second byte 0x5A completes → `valid` stays 1, `data`=0x5A, `overrun`=0.
- Partial frame: 5 sclk rises then cs_n high → `frame_err` and `frame_end` pulse, `valid`=0. The next frame 0x80 is received correctly with bit count reset.
- Reset mid-frame: assert `rst` after 3 bits with cs_n held low and clocking continuing → all outputs 0, no byte delivered. After cs_n goes high and then low with 0xC3 → `data`=0xC3.
